// File: rtl/vadd_bw_iter_ctrl.sv
// ap_ctrl sequencer that runs the vadd_bw kernel a programmable number of times back-to-back.
// Optional elapsed-cycle counter is built when VADD_BW_ITER_CYCLE_CNT_EN is defined.
module vadd_bw_iter_ctrl #(
    parameter bit ADDR_ADVANCE    = 1'b0,
    parameter int ELEM_BYTES_LOG2 = 5
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_ready,
    output logic        ap_idle,
    input  logic [31:0] iters,
    input  logic [63:0] n,
    input  logic [63:0] rmem0,
    input  logic [63:0] wmem0,
    output logic        k_ap_start,
    input  logic        k_ap_ready,
    input  logic        k_ap_done,
    input  logic        k_ap_idle,
    output logic [63:0] k_n,
    output logic [63:0] k_rmem0,
    output logic [63:0] k_wmem0,
    output logic [31:0] iter_count,
    output logic [63:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b11,
        DONE   = 2'b10
    } state_e;

    state_e      state_q;
    logic [31:0] remaining_q;
    logic [31:0] iter_count_q;
    logic [63:0] k_n_q;
    logic [63:0] k_rmem0_q;
    logic [63:0] k_wmem0_q;
    logic        k_ap_start_q;
    logic        ap_done_q;
    logic        ap_idle_q;

    logic [63:0] stride_d;
    logic [63:0] k_rmem0_d;
    logic [63:0] k_wmem0_d;
    logic        iter_done_d;
    logic        last_iter_d;

    // Kernel idle is status only; kept visible so the port is not flagged as dangling.
    logic unused_k_ap_idle;
    assign unused_k_ap_idle = k_ap_idle;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        stride_d    = k_n_q << ELEM_BYTES_LOG2;
        k_rmem0_d   = k_rmem0_q;
        k_wmem0_d   = k_wmem0_q;
        if (ADDR_ADVANCE) begin
            k_rmem0_d = k_rmem0_q + stride_d;
            k_wmem0_d = k_wmem0_q + stride_d;
        end
        // A ready is honoured only while start is actually driven high.
        iter_done_d = ((state_q == LAUNCH) && k_ap_start_q && k_ap_ready && k_ap_done) ||
                      ((state_q == WAIT) && k_ap_done);
        last_iter_d = (remaining_q == 32'd1);
    end

    // NOTE: state uses non-blocking assignments; later assignments in the block override earlier ones.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            iter_count_q <= '0;
            k_n_q        <= '0;
            k_rmem0_q    <= '0;
            k_wmem0_q    <= '0;
            k_ap_start_q <= 1'b0;
            ap_done_q    <= 1'b0;
            ap_idle_q    <= 1'b1;
        end else begin
            ap_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ap_start) begin
                        remaining_q  <= iters;
                        k_n_q        <= n;
                        k_rmem0_q    <= rmem0;
                        k_wmem0_q    <= wmem0;
                        iter_count_q <= '0;
                        ap_idle_q    <= 1'b0;
                        if (iters == 32'd0) begin
                            state_q   <= DONE;
                            ap_done_q <= 1'b1;
                        end else begin
                            state_q      <= LAUNCH;
                            k_ap_start_q <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    if (!k_ap_start_q) begin
                        k_ap_start_q <= 1'b1;
                    end else if (k_ap_ready) begin
                        k_ap_start_q <= 1'b0;
                        if (!k_ap_done) begin
                            state_q <= WAIT;
                        end else if (last_iter_d) begin
                            state_q   <= DONE;
                            ap_done_q <= 1'b1;
                        end
                        // Otherwise stay in LAUNCH with start low: one gap cycle before relaunch.
                    end
                end
                WAIT: begin
                    if (k_ap_done) begin
                        if (last_iter_d) begin
                            state_q   <= DONE;
                            ap_done_q <= 1'b1;
                        end else begin
                            state_q      <= LAUNCH;
                            k_ap_start_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    ap_idle_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase

            if (iter_done_d) begin
                iter_count_q <= iter_count_q + 32'd1;
                remaining_q  <= remaining_q - 32'd1;
                k_rmem0_q    <= k_rmem0_d;
                k_wmem0_q    <= k_wmem0_d;
            end
        end
    end

`ifdef VADD_BW_ITER_CYCLE_CNT_EN
    logic [63:0] cycle_count_q;

    // Counts every LAUNCH/WAIT cycle, start gaps included, saturating at all-ones.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cycle_count_q <= '0;
        end else if ((state_q == IDLE) && ap_start) begin
            cycle_count_q <= '0;
        end else if (((state_q == LAUNCH) || (state_q == WAIT)) && (cycle_count_q != '1)) begin
            cycle_count_q <= cycle_count_q + 64'd1;
        end
    end

    assign cycle_count = cycle_count_q;
`else
    assign cycle_count = '0;
`endif

    assign ap_done    = ap_done_q;
    assign ap_ready   = ap_done_q;
    assign ap_idle    = ap_idle_q;
    assign k_ap_start = k_ap_start_q;
    assign k_n        = k_n_q;
    assign k_rmem0    = k_rmem0_q;
    assign k_wmem0    = k_wmem0_q;
    assign iter_count = iter_count_q;

endmodule

// File: tb/tb_vadd_bw_iter_ctrl.sv
// Self-checking bench for vadd_bw_iter_ctrl: a behavioural kernel responder plus a run-level reference model.
// Follows VADD_BW_ITER_CYCLE_CNT_EN so the expected cycle_count matches the build.
module tb_vadd_bw_iter_ctrl;

    localparam int ELB = 5;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_ready, ap_idle;
    logic [31:0] iters = '0;
    logic [63:0] n = '0, rmem0 = '0, wmem0 = '0;
    logic        k_ap_start;
    logic        k_ap_ready = 1'b0, k_ap_done = 1'b0, k_ap_idle = 1'b1;
    logic [63:0] k_n, k_rmem0, k_wmem0;
    logic [31:0] iter_count;
    logic [63:0] cycle_count;

    vadd_bw_iter_ctrl #(
        .ADDR_ADVANCE   (1'b1),
        .ELEM_BYTES_LOG2(ELB)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_ready   (ap_ready),
        .ap_idle    (ap_idle),
        .iters      (iters),
        .n          (n),
        .rmem0      (rmem0),
        .wmem0      (wmem0),
        .k_ap_start (k_ap_start),
        .k_ap_ready (k_ap_ready),
        .k_ap_done  (k_ap_done),
        .k_ap_idle  (k_ap_idle),
        .k_n        (k_n),
        .k_rmem0    (k_rmem0),
        .k_wmem0    (k_wmem0),
        .iter_count (iter_count),
        .cycle_count(cycle_count)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

`ifdef VADD_BW_ITER_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Kernel responder: ready rdy_dly cycles after start is seen, done done_dly cycles after ready.
    int rdy_dly = 0, done_dly = 0;
    int kph = 0, kcnt = 0;
    bit spur = 1'b0;
    initial begin : kernel_model
        forever begin
            @(negedge ap_clk);
            k_ap_ready = 1'b0;
            k_ap_done  = 1'b0;
            if (!ap_rst_n) begin
                kph = 0;
            end else if (spur && kph == 0) begin
                k_ap_ready = 1'b1;
                k_ap_done  = 1'b1;
                spur = 1'b0;
            end else begin
                if (kph == 0 && k_ap_start) begin
                    kph = 1;
                    kcnt = 0;
                end
                if (kph == 1) begin
                    if (kcnt == rdy_dly) begin
                        k_ap_ready = 1'b1;
                        kcnt = 0;
                        if (done_dly == 0) begin
                            k_ap_done = 1'b1;
                            kph = 0;
                        end else begin
                            kph = 2;
                        end
                    end else begin
                        kcnt++;
                    end
                end else if (kph == 2) begin
                    kcnt++;
                    if (kcnt == done_dly) begin
                        k_ap_done = 1'b1;
                        kph = 0;
                    end
                end
            end
            k_ap_idle = (kph == 0);
        end
    end

    // Monitor: records each kernel launch with the addresses presented on it.
    logic [63:0] launch_r[$], launch_w[$], launch_n[$];
    int          launch_cyc[$];
    int          start_hi_cycles = 0, done_pulses = 0;
    logic        prev_start = 1'b0;
    initial begin : monitor
        forever begin
            @(negedge ap_clk);
            if (k_ap_start && !prev_start) begin
                launch_r.push_back(k_rmem0);
                launch_w.push_back(k_wmem0);
                launch_n.push_back(k_n);
                launch_cyc.push_back(cyc);
            end
            if (k_ap_start) start_hi_cycles++;
            if (ap_done) done_pulses++;
            prev_start = k_ap_start;
        end
    end

    function automatic logic [63:0] exp_addr(input logic [63:0] base, input logic [63:0] nn, input int i);
        logic [63:0] stride;
        stride = nn << ELB;
        return base + 64'(i) * stride;
    endfunction

    // Busy cycles per run: each iteration spends rdy+1 cycles launching and dn waiting;
    // a same-cycle ready+done costs one start gap before the next launch.
    function automatic logic [63:0] exp_busy(input int it, input int rd, input int dn);
        int total;
        total = it * (rd + 1 + dn);
        if (dn == 0 && it > 0) total += it - 1;
        return 64'(total);
    endfunction

    function automatic logic [63:0] exp_cc(input int it, input int rd, input int dn);
        return CNT_EN ? exp_busy(it, rd, dn) : 64'd0;
    endfunction

    task automatic do_run(input logic [31:0] it, input logic [63:0] nn, input logic [63:0] rr,
                          input logic [63:0] ww, input int rd, input int dn, input bit scramble,
                          output bit timeout, output int acc, output int dc,
                          output logic [31:0] ic_done, output logic [63:0] cc_done, output bit ready_ok);
        @(negedge ap_clk);
        rdy_dly = rd;
        done_dly = dn;
        launch_r.delete(); launch_w.delete(); launch_n.delete(); launch_cyc.delete();
        start_hi_cycles = 0;
        done_pulses = 0;
        iters = it; n = nn; rmem0 = rr; wmem0 = ww;
        ap_start = 1'b1;
        acc = cyc;
        dc = -1; ic_done = '0; cc_done = '0; ready_ok = 1'b0;
        @(negedge ap_clk);
        ap_start = 1'b0;
        if (scramble) begin
            iters = $urandom; n = {$urandom, $urandom};
            rmem0 = {$urandom, $urandom}; wmem0 = {$urandom, $urandom};
        end
        timeout = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            if (ap_done) begin
                timeout = 1'b0;
                dc = cyc;
                ic_done = iter_count;
                cc_done = cycle_count;
                ready_ok = (ap_ready === 1'b1);
                break;
            end
            @(negedge ap_clk);
        end
        if (!timeout) @(negedge ap_clk);
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (3) @(negedge ap_clk);
        n_checks++; if (ap_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", ap_idle); end
        n_checks++; if ({ap_done, ap_ready, k_ap_start} !== 3'b000) begin n_fail++;
            $display("FAIL reset_pulses: got %b expected 000", {ap_done, ap_ready, k_ap_start}); end
        n_checks++; if ({k_n, k_rmem0, k_wmem0} !== '0) begin n_fail++;
            $display("FAIL reset_addr: got %0h/%0h/%0h expected 0", k_n, k_rmem0, k_wmem0); end
        n_checks++; if (iter_count !== 32'd0 || cycle_count !== 64'd0) begin n_fail++;
            $display("FAIL reset_counts: got %0d/%0d expected 0/0", iter_count, cycle_count); end
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);
    endtask

    task automatic test_plan_run();
        bit to, rok; int acc, dc; logic [31:0] ic; logic [63:0] cc;
        do_run(32'd3, 64'd16, 64'h1000, 64'h8000, 2, 5, 1'b0, to, acc, dc, ic, cc, rok);
        n_checks++; if (to) begin n_fail++; $display("FAIL plan_timeout: no ap_done within budget"); end
        n_checks++; if (launch_r.size() != 3) begin n_fail++; $display("FAIL plan_launches: got %0d expected 3", launch_r.size()); end
        for (int i = 0; i < launch_r.size() && i < 3; i++) begin
            n_checks++; if (launch_r[i] !== 64'h1000 + 64'(i) * 64'h200 || launch_w[i] !== 64'h8000 + 64'(i) * 64'h200) begin
                n_fail++; $display("FAIL plan_addr%0d: got %0h/%0h expected %0h/%0h", i, launch_r[i], launch_w[i],
                                   64'h1000 + 64'(i) * 64'h200, 64'h8000 + 64'(i) * 64'h200); end
        end
        n_checks++; if (ic !== 32'd3) begin n_fail++; $display("FAIL plan_iter_count: got %0d expected 3", ic); end
        n_checks++; if (!rok) begin n_fail++; $display("FAIL plan_ap_ready: ap_ready not high with ap_done"); end
        n_checks++; if (done_pulses != 1) begin n_fail++; $display("FAIL plan_done_pulses: got %0d expected 1", done_pulses); end
        n_checks++; if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin n_fail++;
            $display("FAIL plan_after_done: got idle=%b done=%b expected 1/0", ap_idle, ap_done); end
        n_checks++; if (cc !== exp_cc(3, 2, 5)) begin n_fail++; $display("FAIL plan_cycle_count: got %0d expected %0d", cc, exp_cc(3, 2, 5)); end
    endtask

    task automatic test_zero_iters();
        bit to, rok; int acc, dc; logic [31:0] ic; logic [63:0] cc;
        do_run(32'd0, 64'd7, 64'hABC0, 64'hDEF0, 1, 1, 1'b0, to, acc, dc, ic, cc, rok);
        n_checks++; if (to || dc != acc + 1) begin n_fail++; $display("FAIL zero_done_latency: got %0d expected %0d", dc - acc, 1); end
        n_checks++; if (start_hi_cycles != 0) begin n_fail++; $display("FAIL zero_no_start: got %0d start cycles expected 0", start_hi_cycles); end
        n_checks++; if (ic !== 32'd0) begin n_fail++; $display("FAIL zero_iter_count: got %0d expected 0", ic); end
        n_checks++; if (k_rmem0 !== 64'hABC0 || k_n !== 64'd7) begin n_fail++;
            $display("FAIL zero_latched: got %0h/%0d expected abc0/7", k_rmem0, k_n); end
    endtask

    task automatic test_ready_done_same();
        bit to, rok; int acc, dc; logic [31:0] ic; logic [63:0] cc;
        do_run(32'd2, 64'd1, 64'h0, 64'h100, 0, 0, 1'b0, to, acc, dc, ic, cc, rok);
        n_checks++; if (to || launch_cyc.size() != 2 || start_hi_cycles != 2) begin n_fail++;
            $display("FAIL same_starts: got %0d launches %0d high cycles expected 2/2", launch_cyc.size(), start_hi_cycles); end
        else begin
            n_checks++; if (launch_cyc[1] - launch_cyc[0] != 2) begin n_fail++;
                $display("FAIL same_gap: got %0d expected 2", launch_cyc[1] - launch_cyc[0]); end
            n_checks++; if (dc != launch_cyc[1] + 1) begin n_fail++;
                $display("FAIL same_done_time: got %0d expected %0d", dc, launch_cyc[1] + 1); end
        end
        n_checks++; if (ic !== 32'd2 || cc !== exp_cc(2, 0, 0)) begin n_fail++;
            $display("FAIL same_counts: got %0d/%0d expected 2/%0d", ic, cc, exp_cc(2, 0, 0)); end
    endtask

    task automatic test_back_to_back();
        int done_seen = 0, idle_run = 0;
        bit after_done = 1'b0;
        int idle_runs[$];
        @(negedge ap_clk);
        rdy_dly = 1; done_dly = 2;
        iters = 32'd1; n = 64'd2; rmem0 = 64'h40; wmem0 = 64'h80;
        ap_start = 1'b1;
        for (int k = 0; k < 300 && done_seen < 3; k++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                done_seen++;
                after_done = 1'b1;
                idle_run = 0;
                n_checks++; if (iter_count !== 32'd1) begin n_fail++; $display("FAIL b2b_iter_count: got %0d expected 1", iter_count); end
            end else if (after_done) begin
                if (ap_idle) idle_run++;
                else begin
                    idle_runs.push_back(idle_run);
                    after_done = 1'b0;
                end
            end
        end
        ap_start = 1'b0;
        n_checks++; if (done_seen != 3 || idle_runs.size() != 2) begin n_fail++;
            $display("FAIL b2b_runs: got %0d done %0d gaps expected 3/2", done_seen, idle_runs.size()); end
        foreach (idle_runs[i]) begin
            n_checks++; if (idle_runs[i] != 1) begin n_fail++; $display("FAIL b2b_idle_gap%0d: got %0d expected 1", i, idle_runs[i]); end
        end
        repeat (2) @(negedge ap_clk);
    endtask

    task automatic test_reset_mid_run();
        bit in_wait = 1'b0;
        @(negedge ap_clk);
        rdy_dly = 1; done_dly = 6;
        launch_cyc.delete(); launch_r.delete(); launch_w.delete(); launch_n.delete();
        iters = 32'd4; n = 64'd3; rmem0 = 64'h2000; wmem0 = 64'h3000;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (launch_cyc.size() == 2 && !k_ap_start && !ap_idle) begin in_wait = 1'b1; break; end
            @(negedge ap_clk);
        end
        n_checks++; if (!in_wait) begin n_fail++; $display("FAIL rst_reach_wait: second iteration WAIT not reached"); end
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        done_pulses = 0;
        n_checks++; if (ap_idle !== 1'b1 || k_ap_start !== 1'b0 || ap_done !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_ctrl: got idle=%b start=%b done=%b expected 1/0/0", ap_idle, k_ap_start, ap_done); end
        n_checks++; if (iter_count !== 32'd0 || k_rmem0 !== 64'd0 || cycle_count !== 64'd0) begin n_fail++;
            $display("FAIL rst_mid_data: got %0d/%0h/%0d expected 0/0/0", iter_count, k_rmem0, cycle_count); end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (12) @(negedge ap_clk);
        n_checks++; if (done_pulses != 0 || launch_cyc.size() != 2 || ap_idle !== 1'b1) begin n_fail++;
            $display("FAIL rst_mid_quiet: got %0d done %0d launches idle=%b expected 0/2/1", done_pulses, launch_cyc.size(), ap_idle); end
    endtask

    task automatic test_cycle_count();
        bit to, rok; int acc, dc; logic [31:0] ic; logic [63:0] cc;
        logic [63:0] want;
        want = CNT_EN ? 64'd10 : 64'd0;
        do_run(32'd1, 64'd8, 64'h0, 64'h0, 0, 9, 1'b0, to, acc, dc, ic, cc, rok);
        n_checks++; if (to || cc !== want) begin n_fail++; $display("FAIL cycle_count: got %0d expected %0d", cc, want); end
        n_checks++; if (dc - acc - 1 != 10) begin n_fail++; $display("FAIL cycle_busy_span: got %0d expected 10", dc - acc - 1); end
        n_checks++; if (cycle_count !== want) begin n_fail++; $display("FAIL cycle_hold: got %0d expected %0d", cycle_count, want); end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 8; r++) begin
            bit to, rok; int acc, dc; logic [31:0] ic; logic [63:0] cc;
            int it, rd, dn; logic [63:0] nn, rr, ww;
            it = $urandom_range(1, 5); rd = $urandom_range(0, 3); dn = $urandom_range(0, 4);
            nn = (r % 2 == 0) ? 64'($urandom_range(1, 4096)) : {$urandom, $urandom};
            rr = {$urandom, $urandom}; ww = {$urandom, $urandom};
            do_run(32'(it), nn, rr, ww, rd, dn, 1'b1, to, acc, dc, ic, cc, rok);
            n_checks++; if (to || ic !== 32'(it) || launch_r.size() != it) begin n_fail++;
                $display("FAIL rand%0d_iters: got %0d count %0d launches expected %0d", r, ic, launch_r.size(), it); end
            for (int i = 0; i < launch_r.size() && i < it; i++) begin
                n_checks++; if (launch_r[i] !== exp_addr(rr, nn, i) || launch_w[i] !== exp_addr(ww, nn, i) || launch_n[i] !== nn) begin
                    n_fail++; $display("FAIL rand%0d_launch%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", r, i, launch_r[i], launch_w[i],
                                       launch_n[i], exp_addr(rr, nn, i), exp_addr(ww, nn, i), nn); end
            end
            n_checks++; if (k_rmem0 !== exp_addr(rr, nn, it) || k_wmem0 !== exp_addr(ww, nn, it)) begin n_fail++;
                $display("FAIL rand%0d_final_addr: got %0h/%0h expected %0h/%0h", r, k_rmem0, k_wmem0, exp_addr(rr, nn, it), exp_addr(ww, nn, it)); end
            n_checks++; if (cc !== exp_cc(it, rd, dn) || dc - acc - 1 != int'(exp_busy(it, rd, dn))) begin n_fail++;
                $display("FAIL rand%0d_cycles: got %0d span %0d expected %0d span %0d", r, cc, dc - acc - 1, exp_cc(it, rd, dn), exp_busy(it, rd, dn)); end
            n_checks++; if (done_pulses != 1 || !rok || iter_count !== 32'(it)) begin n_fail++;
                $display("FAIL rand%0d_done: got %0d pulses ready=%b hold=%0d expected 1/1/%0d", r, done_pulses, rok, iter_count, it); end
        end
    endtask

    task automatic test_spurious_kernel();
        logic [31:0] ic_before;
        @(negedge ap_clk);
        ic_before = iter_count;
        start_hi_cycles = 0;
        done_pulses = 0;
        spur = 1'b1;
        repeat (5) @(negedge ap_clk);
        n_checks++; if (ap_idle !== 1'b1 || start_hi_cycles != 0 || done_pulses != 0) begin n_fail++;
            $display("FAIL spurious_ctrl: got idle=%b starts=%0d dones=%0d expected 1/0/0", ap_idle, start_hi_cycles, done_pulses); end
        n_checks++; if (iter_count !== ic_before) begin n_fail++;
            $display("FAIL spurious_count: got %0d expected %0d", iter_count, ic_before); end
    endtask

    initial begin
        test_reset();
        test_plan_run();
        test_zero_iters();
        test_ready_done_same();
        test_back_to_back();
        test_random_runs();
        test_spurious_kernel();
        test_cycle_count();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
